tree_router_node: RTL and testbench



---
 rtl/tree_router_node.sv | 189 ++++++++++++++++++
 tb/tb_tree_router_node.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_router_node.sv
// tree_router_node: one tree-NoC router node with a parent port (index 0) and
// NUM_CHILD child ports (1..NUM_CHILD). Every input has a FIFO. Every output has
// an arbiter and a registered valid/ready stage.
// Arbitration is set by TREE_ROUTER_RR_ARB_EN. When it is defined, each output
// uses a round-robin arbiter. When it is undefined, the lowest input index wins.
module tree_router_node #(
  parameter int NUM_CHILD   = 2,
  parameter int DATA_W      = 9,
  parameter int ADDR_W      = 4,
  parameter int LEVEL       = 0,
  parameter int NODE_PREFIX = 0,
  parameter int FIFO_DEPTH  = 4,
  localparam int NP         = NUM_CHILD + 1,
  localparam int GW         = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  input  logic [NP*DATA_W-1:0] in_data,
  input  logic [NP-1:0]        in_valid,
  output logic [NP-1:0]        in_ready,
  output logic [NP*DATA_W-1:0] out_data,
  output logic [NP-1:0]        out_valid,
  input  logic [NP-1:0]        out_ready,
  output logic [NP*GW-1:0]     out_grant,
  output logic                 route_err
);

  localparam int CHILD_W = $clog2(NUM_CHILD);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CIDX_LO = LEVEL * CHILD_W;
  localparam int PFX_LO  = (LEVEL + 1) * CHILD_W;

  logic [DATA_W-1:0] r_mem      [NP][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rdPtr    [NP];
  logic [PTR_W-1:0]  r_wrPtr    [NP];
  logic [CNT_W-1:0]  r_count    [NP];
  logic [NP-1:0]     r_inReady;
  logic [DATA_W-1:0] r_outData  [NP];
  logic [GW-1:0]     r_outGrant [NP];
  logic [NP-1:0]     r_outValid;
  logic              r_routeErr;

  logic [DATA_W-1:0] w_head     [NP];
  logic [GW-1:0]     w_dest     [NP];
  logic [NP-1:0]     w_headVld;
  logic [NP-1:0]     w_uturn;
  logic [NP-1:0]     w_req      [NP];
  logic [NP-1:0]     w_load;
  logic [NP-1:0]     w_winVld;
  logic [GW-1:0]     w_winner   [NP];
  logic [NP-1:0]     w_push;
  logic [NP-1:0]     w_pop;
  logic [CNT_W-1:0]  w_countNext [NP];

  // Per-input route decision on the FIFO head. Output registers are unpacked
  // onto the flat buses here.
  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [ADDR_W-1:0]  w_addr;
    logic [CHILD_W-1:0] w_cidx;
    logic               w_pfxOk;

    assign w_head[p]    = r_mem[p][r_rdPtr[p]];
    assign w_headVld[p] = (r_count[p] != '0);
    assign w_addr       = w_head[p][ADDR_W-1:0];
    assign w_cidx       = w_addr[CIDX_LO +: CHILD_W];
    assign w_pfxOk      = (PFX_LO >= ADDR_W) || ((w_addr >> PFX_LO) == ADDR_W'(NODE_PREFIX));
    assign w_dest[p]    = ((p == 0) || w_pfxOk) ? (GW'(w_cidx) + GW'(1)) : '0;
    assign w_uturn[p]   = (p != 0) && w_headVld[p] && (w_dest[p] == GW'(p));

    assign out_data[p*DATA_W +: DATA_W] = r_outData[p];
    assign out_grant[p*GW +: GW]        = r_outGrant[p];
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign route_err = r_routeErr;

`ifdef TREE_ROUTER_RR_ARB_EN
  logic [GW-1:0] r_rrPtr [NP];
`endif

  // Per-output request gathering and winner selection.
  always_comb begin
`ifdef TREE_ROUTER_RR_ARB_EN
    int idx;
    idx = 0;
`endif
    for (int o = 0; o < NP; o++) begin
      w_req[o] = '0;
      for (int p = 0; p < NP; p++) begin
        w_req[o][p] = w_headVld[p] && !w_uturn[p] && (w_dest[p] == GW'(o));
      end
      w_load[o]   = !r_outValid[o] || out_ready[o];
      w_winVld[o] = |w_req[o];
      w_winner[o] = '0;
`ifdef TREE_ROUTER_RR_ARB_EN
      for (int k = NP - 1; k >= 0; k--) begin
        idx = (int'(r_rrPtr[o]) + k) % NP;
        if (w_req[o][idx]) w_winner[o] = GW'(idx);
      end
`else
      for (int k = NP - 1; k >= 0; k--) begin
        if (w_req[o][k]) w_winner[o] = GW'(k);
      end
`endif
    end
  end

  // FIFO push/pop decisions. A head pops when it wins a loading output or when
  // it is a U-turn being dropped.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_push[p] = in_valid[p] && r_inReady[p];
      w_pop[p]  = w_uturn[p];
      for (int o = 0; o < NP; o++) begin
        if (w_load[o] && w_winVld[o] && (w_winner[o] == GW'(p))) w_pop[p] = 1'b1;
      end
      w_countNext[p] = r_count[p] + CNT_W'(w_push[p]) - CNT_W'(w_pop[p]);
    end
  end

  // FIFO storage. Stale contents are harmless because the pointers reset.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < NP; p++) begin
      if (_RESET && w_push[p]) r_mem[p][r_wrPtr[p]] <= in_data[p*DATA_W +: DATA_W];
    end
  end

  // FIFO pointers, occupancy and the registered in_ready derived from occupancy.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      for (int p = 0; p < NP; p++) begin
        r_rdPtr[p] <= '0;
        r_wrPtr[p] <= '0;
        r_count[p] <= '0;
      end
      r_inReady <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (w_push[p]) r_wrPtr[p] <= r_wrPtr[p] + PTR_W'(1);
        if (w_pop[p])  r_rdPtr[p] <= r_rdPtr[p] + PTR_W'(1);
        r_count[p]   <= w_countNext[p];
        r_inReady[p] <= (w_countNext[p] < CNT_W'(FIFO_DEPTH));
      end
    end
  end

  // Output registers and the sticky U-turn error flag.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      for (int o = 0; o < NP; o++) begin
        r_outData[o]  <= '0;
        r_outGrant[o] <= '0;
      end
      r_outValid <= '0;
      r_routeErr <= 1'b0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (w_load[o]) begin
          if (w_winVld[o]) begin
            r_outData[o]  <= w_head[w_winner[o]];
            r_outGrant[o] <= w_winner[o];
            r_outValid[o] <= 1'b1;
          end else begin
            r_outValid[o] <= 1'b0;
          end
        end
      end
      r_routeErr <= r_routeErr | (|w_uturn);
    end
  end

`ifdef TREE_ROUTER_RR_ARB_EN
  // Round-robin pointers move past the winner, and only when the output loads.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      for (int o = 0; o < NP; o++) r_rrPtr[o] <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (w_load[o] && w_winVld[o]) begin
          r_rrPtr[o] <= (w_winner[o] == GW'(NP - 1)) ? '0 : (w_winner[o] + GW'(1));
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tree_router_node.sv
// tb_tree_router_node: directed scenarios plus randomized traffic checked
// against a per-output, per-source ordering scoreboard for tree_router_node.
module tb_tree_router_node;

  localparam int NUM_CHILD   = 2;
  localparam int DATA_W      = 9;
  localparam int ADDR_W      = 4;
  localparam int LEVEL       = 0;
  localparam int NODE_PREFIX = 0;
  localparam int FIFO_DEPTH  = 4;
  localparam int NP          = NUM_CHILD + 1;
  localparam int GW          = $clog2(NP);

  logic                 CLK = 1'b0;
  logic                 rstN;
  logic [NP*DATA_W-1:0] inData;
  logic [NP-1:0]        inValid;
  logic [NP-1:0]        inReady;
  logic [NP*DATA_W-1:0] outData;
  logic [NP-1:0]        outValid;
  logic [NP-1:0]        outReady;
  logic [NP*GW-1:0]     outGrant;
  logic                 routeErr;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [DATA_W-1:0] sb [NP*NP][$];

  tree_router_node #(
    .NUM_CHILD(NUM_CHILD), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .LEVEL(LEVEL), .NODE_PREFIX(NODE_PREFIX), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), ._RESET(rstN),
    .in_data(inData), .in_valid(inValid), .in_ready(inReady),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .out_grant(outGrant), .route_err(routeErr)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Destination port from the addressing rules, using plain arithmetic.
  function automatic int modelRoute(input int src, input logic [DATA_W-1:0] flit);
    int addr;
    int cidx;
    int pfx;
    addr = int'(flit[ADDR_W-1:0]);
    cidx = (addr / (NUM_CHILD ** LEVEL)) % NUM_CHILD;
    pfx  = addr / (NUM_CHILD ** (LEVEL + 1));
    if (src == 0 || pfx == NODE_PREFIX) return cidx + 1;
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] outFlit(input int o);
    return outData[o*DATA_W +: DATA_W];
  endfunction

  function automatic int grantOf(input int o);
    return int'(outGrant[o*GW +: GW]);
  endfunction

  // Drive one input port's flit and valid.
  task automatic applyStimulus(input int p, input logic v, input logic [DATA_W-1:0] d);
    inValid[p] = v;
    inData[p*DATA_W +: DATA_W] = d;
  endtask

  // Reset pulse. Returns at the negedge after the first released edge.
  task automatic applyReset();
    rstN     = 1'b0;
    inValid  = '0;
    outReady = '1;
    repeat (2) @(negedge CLK);
    rstN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    rstN    = 1'b0;
    inValid = '1;
    inData  = {9'h001, 9'h005, 9'h001};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      testsRun++;
      if (inReady !== 3'b000 || outValid !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold: in_ready=%b out_valid=%b expected 000/000", inReady, outValid);
      end
    end
    testsRun++;
    if (outData !== '0 || outGrant !== '0 || routeErr !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: out_data=%h out_grant=%h route_err=%b expected 0", outData, outGrant, routeErr);
    end
    rstN    = 1'b1;
    inValid = '0;
    @(negedge CLK);
    testsRun++;
    if (inReady !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_ready: in_ready=%b expected 111", inReady);
    end
    repeat (3) @(negedge CLK);
    testsRun++;
    if (outValid !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_writes: out_valid=%b expected 000", outValid);
    end
  endtask

  task automatic test_downward();
    applyReset();
    applyStimulus(0, 1'b1, 9'h0A1);
    testsRun++;
    if (inReady[0] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL down_in_ready: got %b expected 1", inReady[0]);
    end
    @(negedge CLK);
    applyStimulus(0, 1'b0, 9'h000);
    testsRun++;
    if (outValid !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL down_early: out_valid=%b expected 000", outValid);
    end
    @(negedge CLK);
    testsRun++;
    if (outValid !== 3'b100 || outFlit(2) !== 9'h0A1 || grantOf(2) !== 0) begin
      testsFailed++;
      $display("[TB] FAIL down_route: out_valid=%b data=%h grant=%0d expected 100/0a1/0",
               outValid, outFlit(2), grantOf(2));
    end
  endtask

  task automatic test_sibling_up();
    logic [DATA_W-1:0] flits [3];
    int expDest [3];
    flits[0] = 9'h101; expDest[0] = 2;
    flits[1] = 9'h105; expDest[1] = 0;
    flits[2] = 9'h100; expDest[2] = -1;
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b1, flits[i]);
      @(negedge CLK);
      applyStimulus(1, 1'b0, 9'h000);
      @(negedge CLK);
      testsRun++;
      if (expDest[i] >= 0) begin
        if (outValid !== NP'(1 << expDest[i]) || outFlit(expDest[i]) !== flits[i] ||
            grantOf(expDest[i]) !== 1 || routeErr !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL sibling_up_%0d: out_valid=%b data=%h grant=%0d err=%b expected port %0d data %h grant 1 err 0",
                   i, outValid, outFlit(expDest[i]), grantOf(expDest[i]), routeErr, expDest[i], flits[i]);
        end
      end else begin
        if (outValid !== 3'b000 || routeErr !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL uturn_drop: out_valid=%b err=%b expected 000/1", outValid, routeErr);
        end
      end
      repeat (2) @(negedge CLK);
    end
    repeat (5) @(negedge CLK);
    testsRun++;
    if (routeErr !== 1'b1 || outValid !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL uturn_sticky: err=%b out_valid=%b expected 1/000", routeErr, outValid);
    end
  endtask

  task automatic test_contention();
    int waited;
    int exp;
    logic [DATA_W-1:0] src [NP];
    src[0] = 9'h000;
    src[1] = 9'h112;
    src[2] = 9'h1A2;
    applyReset();
    applyStimulus(1, 1'b1, src[1]);
    applyStimulus(2, 1'b1, src[2]);
    waited = 0;
    while (outValid[0] !== 1'b1 && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    testsRun++;
    if (outValid[0] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL contention_timeout: out_valid[0]=%b expected 1 within 10 cycles", outValid[0]);
    end else begin
      for (int i = 0; i < 8; i++) begin
`ifdef TREE_ROUTER_RR_ARB_EN
        exp = (i % 2 == 0) ? 1 : 2;
`else
        exp = 1;
`endif
        testsRun++;
        if (outValid[0] !== 1'b1 || grantOf(0) !== exp || outFlit(0) !== src[exp]) begin
          testsFailed++;
          $display("[TB] FAIL contention_grant_%0d: valid=%b grant=%0d data=%h expected grant %0d data %h",
                   i, outValid[0], grantOf(0), outFlit(0), exp, src[exp]);
        end
        @(negedge CLK);
      end
    end
    inValid = '0;
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_backpressure();
    int sent;
    applyReset();
    outReady = 3'b011;
    sent = 0;
    applyStimulus(0, 1'b1, {5'(sent), 4'b0001});
    for (int c = 0; c < 20; c++) begin
      if (inReady[0] !== 1'b1) break;
      sent++;
      @(negedge CLK);
      applyStimulus(0, 1'b1, {5'(sent), 4'b0001});
    end
    applyStimulus(0, 1'b0, 9'h000);
    testsRun++;
    if (sent !== FIFO_DEPTH + 1) begin
      testsFailed++;
      $display("[TB] FAIL bp_accepted: accepted %0d flits expected %0d", sent, FIFO_DEPTH + 1);
    end
    for (int h = 0; h < 3; h++) begin
      testsRun++;
      if (outValid[2] !== 1'b1 || outFlit(2) !== {5'd0, 4'b0001} || grantOf(2) !== 0 || inReady[0] !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b data=%h grant=%0d in_ready=%b expected 1/001/0/0",
                 h, outValid[2], outFlit(2), grantOf(2), inReady[0]);
      end
      @(negedge CLK);
    end
    outReady[2] = 1'b1;
    testsRun++;
    if (inReady[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_full_pop_ready: in_ready=%b expected 0", inReady[0]);
    end
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      testsRun++;
      if (outValid[2] !== 1'b1 || outFlit(2) !== {5'(i), 4'b0001}) begin
        testsFailed++;
        $display("[TB] FAIL bp_drain_%0d: valid=%b data=%h expected 1/%h", i, outValid[2], outFlit(2), {5'(i), 4'b0001});
      end
      @(negedge CLK);
    end
    testsRun++;
    if (outValid[2] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_empty: out_valid[2]=%b expected 0", outValid[2]);
    end
  endtask

  task automatic test_random();
    logic expErr;
    int d;
    int g;
    int left;
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] expFlit;
    applyReset();
    expErr = 1'b0;
    for (int i = 0; i < NP * NP; i++) sb[i].delete();
    for (int cyc = 0; cyc < 460; cyc++) begin
      for (int o = 0; o < NP; o++) outReady[o] = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      for (int p = 0; p < NP; p++) begin
        applyStimulus(p, (cyc < 400) && ($urandom_range(0, 9) < 6), DATA_W'($urandom));
      end
      for (int p = 0; p < NP; p++) begin
        if (inValid[p] && inReady[p]) begin
          f = inData[p*DATA_W +: DATA_W];
          d = modelRoute(p, f);
          if (p != 0 && d == p) expErr = 1'b1;
          else sb[d*NP + p].push_back(f);
        end
      end
      for (int o = 0; o < NP; o++) begin
        if (outValid[o] && outReady[o]) begin
          g = grantOf(o);
          testsRun++;
          if (g >= NP || sb[o*NP + g].size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL rand_unexpected: port %0d data=%h grant=%0d with no flit expected", o, outFlit(o), g);
          end else begin
            expFlit = sb[o*NP + g].pop_front();
            if (outFlit(o) !== expFlit) begin
              testsFailed++;
              $display("[TB] FAIL rand_data: port %0d from %0d got %h expected %h", o, g, outFlit(o), expFlit);
            end
          end
        end
      end
      @(negedge CLK);
    end
    left = 0;
    for (int i = 0; i < NP * NP; i++) left += sb[i].size();
    testsRun++;
    if (left != 0 || outValid !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL rand_drain: %0d flits undelivered, out_valid=%b expected 0/000", left, outValid);
    end
    testsRun++;
    if (routeErr !== expErr) begin
      testsFailed++;
      $display("[TB] FAIL rand_route_err: got %b expected %b", routeErr, expErr);
    end
  endtask

  // Test sequence.
  initial begin
    rstN     = 1'b0;
    inValid  = '0;
    inData   = '0;
    outReady = '1;
    repeat (2) @(negedge CLK);
    test_reset();
    test_downward();
    test_sibling_up();
    test_contention();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
